sample_spi_tx: RTL

Downstream consumer of the datapath sequencer. It latches the processed audio sample on the sequencer's one-cycle tfr_ready pulse and shifts it MSB-first to the MCU over SPI, acting as the SPI slave in mode 0 (CPOL=0, CPHA=0). While a frame is pending or in flight it holds `transmit` high. This keeps the sequencer parked in its MCU-transfer state until the MCU completes the frame.

---
 rtl/sample_spi_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sample_spi_tx.sv
// SPI mode-0 slave transmitter: latches one sample on tfr_ready and shifts it
// out MSB-first on sdo, holding transmit high until the MCU closes the frame.
module sample_spi_tx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tfr_ready,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sck,
  input  logic              cs_n,
  output logic              sdo,
  output logic              transmit,
  output logic              overrun,
  output logic              aborted
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_W-1:0]       shreg, shreg_nxt;
  logic [CNT_W-1:0]        bitcnt, bitcnt_nxt;
  logic                    overrun_nxt, aborted_nxt;

  logic [SYNC_STAGES-1:0]  sck_sync, cs_sync;
  logic                    sck_q, cs_q;
  logic                    sck_s, cs_s;
  logic                    sck_rise, sck_fall, cs_rise, cs_fall;

  // Synchronizers reset to the bus idle level so no phantom edge follows reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_q    <= sck_s;
      cs_q     <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_q;
  assign sck_fall = ~sck_s &  sck_q;
  assign cs_rise  =  cs_s  & ~cs_q;
  assign cs_fall  = ~cs_s  &  cs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      overrun <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bitcnt  <= bitcnt_nxt;
      overrun <= overrun_nxt;
      aborted <= aborted_nxt;
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bitcnt_nxt  = bitcnt;
    overrun_nxt = overrun;
    aborted_nxt = aborted;

    if (tfr_ready && state != IDLE)
      overrun_nxt = 1'b1;

    unique case (state)
      IDLE: begin
        if (tfr_ready) begin
          shreg_nxt   = sample_in;
          bitcnt_nxt  = '0;
          overrun_nxt = 1'b0;
          aborted_nxt = 1'b0;
          state_nxt   = LOADED;
        end
      end
      LOADED: begin
        // Any SCK edge coinciding with the cs_n fall is deliberately dropped.
        if (cs_fall)
          state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          if (bitcnt < CNT_MAX)
            aborted_nxt = 1'b1;
          shreg_nxt  = '0;
          bitcnt_nxt = '0;
          state_nxt  = IDLE;
        end else if (sck_rise) begin
          if (bitcnt < CNT_MAX)
            bitcnt_nxt = bitcnt + CNT_W'(1);
          if (bitcnt >= CNT_MAX - CNT_W'(1))
            state_nxt = DONE;
        end else if (sck_fall && bitcnt < CNT_MAX) begin
          shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        if (cs_rise) begin
          shreg_nxt  = '0;
          bitcnt_nxt = '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both outputs decode the state register, so reset clears them asynchronously.
  assign transmit = (state != IDLE);
  assign sdo      = (state == LOADED || state == SHIFT) ? shreg[DATA_W-1] : 1'b0;

endmodule
